op_scheduler: RTL and testbench
===============================

OP_SCHEDULER -- requirements
Module: op_scheduler

Parameters
REQ-001 ADDRW, 8, address width of key/text/result pointers.
REQ-002 OPCODEW, 2, opcode width.
REQ-003 FIFO_DEPTH, 4, instruction queue entries; power of two, at least 2.
REQ-004 TIMEOUT, 255, maximum clk cycles to wait for core_done.

Interface
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 valid_in  in  1  instruction present from deserializer.
REQ-008 opcode  in  OPCODEW  00 NOP, 01 KEY_LOAD, 10 ENCRYPT, 11 DECRYPT.
REQ-009 key_addr, text_addr  in  ADDRW each  operand pointers.
REQ-010 ready_out  out  1  queue can accept; drives deserializer ready_in.
REQ-011 mem_req, mem_we  out  1 each  memory bus request and write flag.
REQ-012 mem_addr  out  ADDRW  memory bus address.
REQ-013 mem_gnt  in  1  memory bus grant, completes current request.
REQ-014 core_start  out  1  one-cycle start pulse to crypto core.
REQ-015 core_mode  out  1  0 encrypt, 1 decrypt; valid while core runs.
REQ-016 core_done  in  1  core finished, result ready.
REQ-017 busy  out  1  FSM not IDLE or queue non-empty.
REQ-018 err  out  1  one-cycle pulse on core timeout.

Function
REQ-019 Push when valid_in && ready_out; ready_out = !full; {opcode,key_addr,text_addr} stored.
REQ-020 NOP pushed but discarded on pop with no bus or core activity; one idle cycle.
REQ-021 FSM states: IDLE, FETCH_KEY, FETCH_TEXT, RUN, WAIT_CORE, STORE.
REQ-022 IDLE with queue non-empty pops head; next state FETCH_KEY, or IDLE for NOP.
REQ-023 Simultaneous push and pop permitted in one cycle, including when full; occupancy unchanged.
REQ-024 Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit or count.
REQ-025 FETCH_KEY: mem_req=1, mem_we=0, mem_addr=key_addr; held stable until mem_gnt=1.
REQ-026 When mem_gnt=1 in FETCH_KEY: KEY_LOAD returns to IDLE; others go to FETCH_TEXT.
REQ-027 FETCH_TEXT: mem_req=1, mem_we=0, mem_addr=text_addr; on mem_gnt, go to RUN.
REQ-028 RUN lasts one cycle with core_start=1 and core_mode=opcode[0]; next state WAIT_CORE.
REQ-029 WAIT_CORE increments an 8-bit cycle counter from 0.
REQ-030 In WAIT_CORE, core_done=1 leads to STORE.
REQ-031 If the counter reaches TIMEOUT without core_done: err=1 for one cycle, FSM returns to IDLE, and the instruction is dropped.
REQ-032 core_done and timeout in the same cycle: core_done wins, no err.
REQ-033 STORE: mem_req=1, mem_we=1, mem_addr=text_addr; on mem_gnt, go to IDLE.
REQ-034 mem_req is 0 in IDLE, RUN and WAIT_CORE.
REQ-035 core_done outside WAIT_CORE is ignored.
REQ-036 mem_gnt without mem_req is ignored.
REQ-037 Earliest restart: the next pop occurs the cycle after return to IDLE.

Reset
REQ-038 rst_n low immediately forces IDLE and empties the queue.
REQ-039 Under reset: ready_out=0; mem_req=0; mem_we=0; mem_addr=0; core_start=0; core_mode=0; busy=0; err=0; counter=0.
REQ-040 ready_out rises the first clk edge after rst_n is released.
REQ-041 Reset mid-operation abandons the transaction with no completion pulse.

Verification
REQ-042 ENCRYPT, key 0xAA, text 0x55, mem_gnt tied 1, core_done 3 cycles after start:
  - mem_addr sequence AA(rd), 55(rd), 55(wr).
  - core_mode=0.
  - busy falls the cycle after the write grant.
REQ-043 DECRYPT 0x5A/0xC3 with mem_gnt delayed 2 cycles per request:
  - address and we held stable through the wait.
  - core_mode=1.
REQ-044 KEY_LOAD 0x0F followed by NOP:
  - single read of 0x0F, no core_start.
  - NOP produces no bus activity.
REQ-045 Core never asserts core_done: a single err pulse TIMEOUT cycles after core_start, then the next queued instruction proceeds.
REQ-046 Five back-to-back valid_in while the FSM is stalled on mem_gnt=0:
  - ready_out=0 after the 4th push.
  - 5th accepted only after the first pop.
  - all execute in order.
REQ-047 rst_n asserted during WAIT_CORE: all outputs take reset values immediately; a later ENCRYPT runs normally.

Source files
------------

// File: rtl/op_scheduler.sv
// op_scheduler: queues crypto instructions and sequences key fetch, text fetch,
//   core run and result store on a shared memory bus.
// Latency: an instruction pushed into an empty idle queue is popped the next
//   cycle. Its first bus request appears the cycle after that.
// Backpressure: o_ready_out drops while the queue is full. The bus stalls on
//   i_mem_gnt with address and write flag held. The core wait is bounded by TIMEOUT.
// Ports:
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_valid_in, i_opcode,
//   i_key_addr, i_text_addr               instruction push from the deserializer
//   o_ready_out                           queue can accept an instruction
//   o_mem_req, o_mem_we, o_mem_addr,
//   i_mem_gnt                             memory bus request/grant
//   o_core_start, o_core_mode,
//   i_core_done                           crypto core control
//   o_busy, o_err                         status and timeout pulse

// op_scheduler_fifo: generic synchronous FIFO with head-of-queue read.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: o_full is reported. A push while full is taken only together with a pop.
module op_scheduler_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // The extra MSB on each pointer separates full (MSBs differ) from empty.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                      (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_pop      = i_pop && !o_empty;
  assign w_push     = i_push && (!o_full || w_pop);
  assign o_head_dat = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_push_dat;
  end
endmodule

module op_scheduler #(
  parameter int ADDRW      = 8,
  parameter int OPCODEW    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid_in,
  input  logic [OPCODEW-1:0] i_opcode,
  input  logic [ADDRW-1:0]   i_key_addr,
  input  logic [ADDRW-1:0]   i_text_addr,
  output logic               o_ready_out,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [ADDRW-1:0]   o_mem_addr,
  input  logic               i_mem_gnt,
  output logic               o_core_start,
  output logic               o_core_mode,
  input  logic               i_core_done,
  output logic               o_busy,
  output logic               o_err
);
  localparam int IW = OPCODEW + 2 * ADDRW;
  localparam logic [OPCODEW-1:0] OP_NOP      = OPCODEW'(0);
  localparam logic [OPCODEW-1:0] OP_KEY_LOAD = OPCODEW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_KEY, S_FETCH_TEXT, S_RUN, S_WAIT_CORE, S_STORE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_rdy_en;
  logic [OPCODEW-1:0] r_op;
  logic [ADDRW-1:0]   r_key;
  logic [ADDRW-1:0]   r_text;
  logic [7:0]         r_cnt;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [IW-1:0]      w_head;
  logic [OPCODEW-1:0] w_head_op;
  logic               w_timeout;

  // r_rdy_en keeps ready low during reset and raises it on the first edge after release.
  assign o_ready_out = r_rdy_en && !w_full;
  assign w_push      = i_valid_in && o_ready_out;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head_op   = w_head[IW-1 -: OPCODEW];
  assign o_busy      = (r_state != S_IDLE) || !w_empty;
  // The counter holds 0 on the first WAIT_CORE cycle. This gives the core TIMEOUT
  // cycles to answer, and the last of them is the one that would advance the count to TIMEOUT.
  assign w_timeout   = (r_cnt == 8'(TIMEOUT - 1));

  op_scheduler_fifo #(.WIDTH(IW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_push_dat ({i_opcode, i_key_addr, i_text_addr}),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_comb begin
    w_state_nxt  = r_state;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_core_start = 1'b0;
    o_core_mode  = 1'b0;
    o_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A NOP is consumed here and costs exactly one idle cycle.
        if (!w_empty) w_state_nxt = (w_head_op == OP_NOP) ? S_IDLE : S_FETCH_KEY;
      end
      S_FETCH_KEY: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_key;
        if (i_mem_gnt) w_state_nxt = (r_op == OP_KEY_LOAD) ? S_IDLE : S_FETCH_TEXT;
      end
      S_FETCH_TEXT: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_text;
        if (i_mem_gnt) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_core_start = 1'b1;
        o_core_mode  = r_op[0];
        w_state_nxt  = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        o_core_mode = r_op[0];
        // If done and timeout land on the same cycle, done wins.
        if (i_core_done) begin
          w_state_nxt = S_STORE;
        end else if (w_timeout) begin
          o_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_STORE: begin
        o_mem_req  = 1'b1;
        o_mem_we   = 1'b1;
        o_mem_addr = r_text;
        if (i_mem_gnt) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_rdy_en <= 1'b0;
      r_op     <= '0;
      r_key    <= '0;
      r_text   <= '0;
      r_cnt    <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
      if (w_pop) begin
        r_op   <= w_head_op;
        r_key  <= w_head[2*ADDRW-1 -: ADDRW];
        r_text <= w_head[ADDRW-1:0];
      end
      r_cnt <= (r_state == S_WAIT_CORE) ? r_cnt + 8'd1 : 8'd0;
    end
  end
endmodule

// File: tb/tb_op_scheduler.sv
module tb_op_scheduler;
  localparam logic [1:0] NOP = 2'b00, KL = 2'b01, ENC = 2'b10, DEC = 2'b11;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_valid_in, i_mem_gnt, i_core_done;
  logic [1:0] i_opcode;
  logic [7:0] i_key_addr, i_text_addr;
  logic       o_ready_out, o_mem_req, o_mem_we, o_core_start, o_core_mode, o_busy, o_err;
  logic [7:0] o_mem_addr;

  int nchecks = 0;
  int nfail = 0;
  int cyc = 0;
  int n_events = 0;
  logic mon_en = 1'b0;
  logic [9:0] exp_q[$];
  logic p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
  logic [7:0] p_addr = 8'h00;

  typedef struct {
    logic v; logic [1:0] op; logic [7:0] ka; logic [7:0] ta; logic g; logic d;
    logic [14:0] want;
  } vec_t;
  vec_t vecs[$];

  op_scheduler dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid_in(i_valid_in), .i_opcode(i_opcode),
    .i_key_addr(i_key_addr), .i_text_addr(i_text_addr), .o_ready_out(o_ready_out),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .i_mem_gnt(i_mem_gnt), .o_core_start(o_core_start), .o_core_mode(o_core_mode),
    .i_core_done(i_core_done), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [14:0] outs();
    return {o_ready_out, o_mem_req, o_mem_we, o_mem_addr, o_core_start, o_core_mode, o_busy, o_err};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [1:0] op, input logic [7:0] ka, ta,
                               input logic g, d, rdy, req, we, input logic [7:0] addr,
                               input logic st, md, bsy, er);
    vec_t r;
    r.v = v; r.op = op; r.ka = ka; r.ta = ta; r.g = g; r.d = d;
    r.want = {rdy, req, we, addr, st, md, bsy, er};
    return r;
  endfunction

  task automatic drv(input logic v, input logic [1:0] op, input logic [7:0] k, input logic [7:0] t);
    i_valid_in = v; i_opcode = op; i_key_addr = k; i_text_addr = t;
  endtask

  task automatic step();
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
  endtask

  // Transaction-level reference: each accepted instruction expands into its bus/core
  // events in program order, and the events the DUT produces must match that stream.
  task automatic obs(input logic [9:0] ev);
    logic [9:0] want;
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
    n_events++;
    chk("event_order", ev, want);
  endtask

  always @(negedge i_clk) begin
    if (mon_en && i_rst_n) begin
      if (i_valid_in && o_ready_out) begin
        case (i_opcode)
          NOP: ;
          KL:  exp_q.push_back({2'd0, i_key_addr});
          default: begin
            exp_q.push_back({2'd0, i_key_addr});
            exp_q.push_back({2'd0, i_text_addr});
            exp_q.push_back({2'd2, 7'd0, i_opcode[0]});
            exp_q.push_back({2'd1, i_text_addr});
          end
        endcase
      end
      if (o_mem_req && i_mem_gnt) obs({1'b0, o_mem_we, o_mem_addr});
      if (o_core_start) obs({2'd2, 7'd0, o_core_mode});
      chk("no_err", o_err, 1'b0);
      if (p_req && !p_gnt) chk("req_held", {o_mem_req, o_mem_we, o_mem_addr}, {1'b1, p_we, p_addr});
      p_req <= o_mem_req; p_gnt <= i_mem_gnt; p_we <= o_mem_we; p_addr <= o_mem_addr;
    end else begin
      p_req <= 1'b0;
    end
  end

  task automatic drain(input string nm, input int budget);
    logic idle;
    idle = 1'b0;
    i_valid_in = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      i_mem_gnt = 1'($urandom % 2); i_core_done = 1'($urandom % 2);
      @(negedge i_clk);
      if (!o_busy) idle = 1'b1;
      @(posedge i_clk); #1;
    end
    chk({nm, "_idle"}, idle, 1'b1);
    chk({nm, "_all_done"}, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen, got_req, req_we;
    logic [7:0] req_addr;
    int t_start, t_err, nerr, base;
    i_rst_n = 1'b0; i_mem_gnt = 1'b0; i_core_done = 1'b0;
    drv(1'b0, NOP, 8'h00, 8'h00);

    // ENCRYPT AA/55, grant tied high, done three cycles after start
    vecs.push_back(mkv(1, ENC, 8'hAA, 8'h55, 1, 0,  1, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 1, 0, 8'hAA, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 1, 0, 8'h55, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 0, 0, 8'h00, 1, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 1,  1, 0, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 1, 1, 8'h55, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 0, 0));
    // DECRYPT 5A/C3, each grant two cycles late; stray grant in IDLE and stray done in FETCH_KEY
    vecs.push_back(mkv(1, DEC, 8'h5A, 8'hC3, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 0, 1,  1, 1, 0, 8'h5A, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 0, 0,  1, 1, 0, 8'h5A, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 1, 0, 8'h5A, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 0, 0,  1, 1, 0, 8'hC3, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 0, 0,  1, 1, 0, 8'hC3, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 1, 0, 8'hC3, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 0, 0,  1, 0, 0, 8'h00, 1, 1, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 0, 0,  1, 1, 1, 8'hC3, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 0, 0,  1, 1, 1, 8'hC3, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 1, 1, 8'hC3, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 0, 0,  1, 0, 0, 8'h00, 0, 0, 0, 0));
    // KEY_LOAD 0F followed by NOP
    vecs.push_back(mkv(1, KL,  8'h0F, 8'h77, 1, 0,  1, 0, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mkv(1, NOP, 8'h33, 8'h44, 1, 0,  1, 0, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 1, 0, 8'h0F, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mkv(0, NOP, 8'h00, 8'h00, 1, 0,  1, 0, 0, 8'h00, 0, 0, 0, 0));

    // Reset state and ready release timing
    repeat (2) @(negedge i_clk);
    chk("reset_outputs", outs(), 15'h0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk); chk("ready_low_before_first_edge", o_ready_out, 1'b0);
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("ready_high_after_first_edge", o_ready_out, 1'b1);
    @(posedge i_clk); #1;

    foreach (vecs[i]) begin
      drv(vecs[i].v, vecs[i].op, vecs[i].ka, vecs[i].ta);
      i_mem_gnt = vecs[i].g; i_core_done = vecs[i].d;
      @(negedge i_clk);
      chk($sformatf("vec%0d", i), outs(), vecs[i].want);
      @(posedge i_clk); #1;
    end

    // Core timeout, then the queued KEY_LOAD must proceed
    i_mem_gnt = 1'b1; i_core_done = 1'b0;
    drv(1'b1, ENC, 8'h11, 8'h22); step();
    drv(1'b1, KL, 8'h33, 8'h00); step();
    i_valid_in = 1'b0;
    seen = 1'b0; t_start = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge i_clk);
      if (o_core_start) begin seen = 1'b1; t_start = cyc; end
      @(posedge i_clk); #1;
    end
    chk("timeout_start_seen", seen, 1'b1);
    nerr = 0; t_err = 0;
    for (int i = 0; i < 300 && nerr == 0; i++) begin
      @(negedge i_clk);
      if (o_err) begin nerr++; t_err = cyc; end
      @(posedge i_clk); #1;
    end
    chk("timeout_latency", t_err - t_start, 255);
    got_req = 1'b0; req_we = 1'b0; req_addr = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_err) nerr++;
      if (o_mem_req && !got_req) begin got_req = 1'b1; req_we = o_mem_we; req_addr = o_mem_addr; end
      @(posedge i_clk); #1;
    end
    chk("timeout_single_err", nerr, 1);
    chk("next_after_timeout", {got_req, req_we, req_addr}, {1'b1, 1'b0, 8'h33});
    @(negedge i_clk); chk("idle_after_timeout", o_busy, 1'b0);
    @(posedge i_clk); #1;

    // Five back-to-back pushes while FETCH_KEY is stalled on the grant
    exp_q.delete(); mon_en = 1'b1;
    i_mem_gnt = 1'b0; i_core_done = 1'b1;
    drv(1'b1, KL, 8'h10, 8'h00); step();
    for (int k = 1; k <= 4; k++) begin
      drv(1'b1, (k % 2 == 1) ? ENC : DEC, 8'(8'h20 + k), 8'(8'h40 + k)); step();
    end
    drv(1'b1, ENC, 8'h25, 8'h45);
    @(negedge i_clk); chk("full_after_4_pushes", o_ready_out, 1'b0);
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("full_while_stalled", o_ready_out, 1'b0);
    @(posedge i_clk); #1;
    i_mem_gnt = 1'b1;
    @(negedge i_clk); chk("no_accept_before_pop", o_ready_out, 1'b0);
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("no_accept_in_pop_cycle", o_ready_out, 1'b0);
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("accept_after_pop", o_ready_out, 1'b1);
    @(posedge i_clk); #1;
    drain("backpressure", 400);

    // Reset in WAIT_CORE, then a normal ENCRYPT
    mon_en = 1'b0;
    i_mem_gnt = 1'b1; i_core_done = 1'b0;
    drv(1'b1, ENC, 8'h01, 8'h02); step();
    i_valid_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge i_clk);
      if (o_core_start) seen = 1'b1;
      @(posedge i_clk); #1;
    end
    chk("midreset_start_seen", seen, 1'b1);
    repeat (3) step();
    #2 i_rst_n = 1'b0;
    #1 chk("reset_mid_wait_outputs", outs(), 15'h0);
    @(negedge i_clk); chk("held_in_reset", outs(), 15'h0);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk); chk("midreset_ready_low", o_ready_out, 1'b0);
    @(posedge i_clk); #1;
    @(negedge i_clk); chk("midreset_ready_high", o_ready_out, 1'b1);
    @(posedge i_clk); #1;
    exp_q.delete(); mon_en = 1'b1; base = n_events;
    drv(1'b1, ENC, 8'h66, 8'h77); step();
    drain("post_reset", 200);
    chk("post_reset_event_count", n_events - base, 3'd4);

    // Randomized traffic against the transaction-level reference
    for (int c = 0; c < 400; c++) begin
      drv(1'(($urandom % 3) == 0), 2'($urandom), 8'($urandom), 8'($urandom));
      i_mem_gnt = 1'($urandom % 2);
      i_core_done = 1'(($urandom % 4) == 0);
      step();
    end
    drain("random", 800);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end
endmodule
